// File: rtl/bp_hard_decision_syndrome.sv
// Hard-decision slicer and serial 3-row parity-check syndrome for the BP decoder.
// Samples a 6-column LLR vector, decides one column per cycle, checks one row per cycle.
module bp_hard_decision_syndrome #(
   parameter logic [17:0] H_MATRIX = 18'b110001_010110_001011
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [191:0] sum_vector,
   output logic         busy,
   output logic         done,
   output logic [5:0]   codeword,
   output logic [2:0]   syndrome,
   output logic         valid_codeword,
   output logic         nan_detected
);

   localparam int unsigned N_COLS = 6;
   localparam int unsigned N_ROWS = 3;
   localparam int unsigned LLR_W  = 32;
   localparam int unsigned VEC_W  = N_COLS * LLR_W;
   localparam int unsigned COL_W  = 3;
   localparam int unsigned ROW_W  = 2;

   typedef enum logic [1:0] {IDLE, DECIDE, CHECK, DONE} state_t;

   state_t              state, state_n;
   logic [COL_W-1:0]    col, col_n;
   logic [ROW_W-1:0]    row, row_n;
   logic [VEC_W-1:0]    vec, vec_n;
   logic [N_COLS-1:0]   dec, dec_n;
   logic [N_ROWS-1:0]   syn_w, syn_n;
   logic                nan_w, nan_n;
   logic                busy_n, done_n, valid_n, nan_det_n;
   logic [N_COLS-1:0]   codeword_n;
   logic [N_ROWS-1:0]   syndrome_n;

   logic [LLR_W-1:0]    llr;
   logic                llr_nan;
   logic [N_COLS-1:0]   h_row;

   // Current column operand and its NaN classification
   always_comb begin
      llr     = vec[{col, 5'b00000} +: LLR_W];
      llr_nan = (&llr[30:23]) && (|llr[22:0]);
   end

   // Row of H selected by the row counter
   always_comb begin
      case (row)
         2'd0:    h_row = H_MATRIX[5:0];
         2'd1:    h_row = H_MATRIX[11:6];
         default: h_row = H_MATRIX[17:12];
      endcase
   end

   // State register and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         col            <= '0;
         row            <= '0;
         vec            <= '0;
         dec            <= '0;
         syn_w          <= '0;
         nan_w          <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         codeword       <= '0;
         syndrome       <= '0;
         valid_codeword <= 1'b0;
         nan_detected   <= 1'b0;
      end else begin
         state          <= state_n;
         col            <= col_n;
         row            <= row_n;
         vec            <= vec_n;
         dec            <= dec_n;
         syn_w          <= syn_n;
         nan_w          <= nan_n;
         busy           <= busy_n;
         done           <= done_n;
         codeword       <= codeword_n;
         syndrome       <= syndrome_n;
         valid_codeword <= valid_n;
         nan_detected   <= nan_det_n;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_n    = state;
      col_n      = col;
      row_n      = row;
      vec_n      = vec;
      dec_n      = dec;
      syn_n      = syn_w;
      nan_n      = nan_w;
      done_n     = 1'b0;
      codeword_n = codeword;
      syndrome_n = syndrome;
      valid_n    = valid_codeword;
      nan_det_n  = nan_detected;

      case (state)
         IDLE: begin
            if (start) begin
               vec_n   = sum_vector;
               dec_n   = '0;
               syn_n   = '0;
               nan_n   = 1'b0;
               col_n   = '0;
               state_n = DECIDE;
            end
         end
         DECIDE: begin
            // Negative and nonzero decides 1; a NaN never decides 1
            dec_n[col] = llr[31] && (|llr[30:0]) && !llr_nan;
            if (llr_nan) nan_n = 1'b1;
            if (col == COL_W'(N_COLS - 1)) begin
               col_n   = '0;
               row_n   = '0;
               state_n = CHECK;
            end else begin
               col_n = col + COL_W'(1);
            end
         end
         CHECK: begin
            syn_n[row] = ^(h_row & dec);
            if (row == ROW_W'(N_ROWS - 1)) begin
               row_n      = '0;
               state_n    = DONE;
               done_n     = 1'b1;
               codeword_n = dec;
               syndrome_n = syn_n;
               nan_det_n  = nan_w;
               valid_n    = (syn_n == '0) && !nan_w;
            end else begin
               row_n = row + ROW_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      busy_n = (state_n != IDLE);
   end

endmodule

// File: tb/tb_bp_hard_decision_syndrome.sv
// Scoreboard bench for bp_hard_decision_syndrome: directed and random LLR vectors
// against a column/row reference model, with latency, hold, ignore-start and reset checks.
module tb_bp_hard_decision_syndrome;

   localparam logic [17:0] H = 18'b110001_010110_001011;

   typedef struct {
      logic [5:0] cw;
      logic [2:0] syn;
      logic       nan;
      logic       valid;
      int         e0;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [191:0] sum_vector;
   logic         busy, done, valid_codeword, nan_detected;
   logic [5:0]   codeword;
   logic [2:0]   syndrome;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sb[$];
   logic [5:0] last_cw;
   logic [2:0] last_syn;

   bp_hard_decision_syndrome #(.H_MATRIX(H)) dut (
      .clk(clk), .reset(reset), .start(start), .sum_vector(sum_vector),
      .busy(busy), .done(done), .codeword(codeword), .syndrome(syndrome),
      .valid_codeword(valid_codeword), .nan_detected(nan_detected)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: decide each column from its float fields, then count parity per row
   function automatic exp_t model(input logic [191:0] v, input int e0);
      exp_t e;
      logic [31:0] w;
      bit d[6];
      bit is_nan;
      int ones;
      e.nan = 1'b0;
      e.cw  = '0;
      e.syn = '0;
      for (int c = 0; c < 6; c++) begin
         w = v[32*c +: 32];
         is_nan = (w[30:23] == 8'hFF) && (w[22:0] != 0);
         d[c] = (w[31] == 1'b1) && (w[30:0] != 0) && !is_nan;
         if (is_nan) e.nan = 1'b1;
         e.cw[c] = d[c];
      end
      for (int r = 0; r < 3; r++) begin
         ones = 0;
         for (int c = 0; c < 6; c++) if (H[r*6+c] && d[c]) ones++;
         e.syn[r] = (ones % 2) == 1;
      end
      e.valid = (e.syn == 0) && !e.nan;
      e.e0 = e0;
      return e;
   endfunction

   function automatic logic [31:0] rand_llr();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'h8000_0000;
         2:       return 32'h7F80_0000;
         3:       return 32'hFF80_0000;
         4:       return {1'($urandom_range(0, 1)), 8'hFF, 23'($urandom_range(1, 23'h7FFFFF))};
         5:       return 32'h8000_0001;
         default: return $urandom();
      endcase
   endfunction

   // Monitor: pops the scoreboard on every done pulse
   task automatic monitor();
      exp_t e;
      forever begin
         @(negedge clk);
         if (done) begin
            if (sb.size() == 0) begin
               check("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               check("done_latency", cyc - e.e0, 9);
               check("codeword", int'(codeword), int'(e.cw));
               check("syndrome", int'(syndrome), int'(e.syn));
               check("nan_detected", int'(nan_detected), int'(e.nan));
               check("valid_codeword", int'(valid_codeword), int'(e.valid));
               last_cw  = e.cw;
               last_syn = e.syn;
            end
         end
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (busy && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (busy) check("idle_timeout", 1, 0);
   endtask

   // Issue one start; returns at the negedge right after the sampling edge E0
   task automatic issue(input logic [191:0] v, input bit push);
      wait_idle();
      start = 1'b1;
      sum_vector = v;
      if (push) sb.push_back(model(v, cyc + 1));
      @(negedge clk);
      start = 1'b0;
      sum_vector = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
      check("busy_after_start", int'(busy), 1);
      check("hold_codeword", int'(codeword), int'(last_cw));
      check("hold_syndrome", int'(syndrome), int'(last_syn));
   endtask

   initial begin
      logic [191:0] v;
      int e0;
      int n;
      last_cw  = '0;
      last_syn = '0;
      reset = 1'b1;
      start = 1'b0;
      sum_vector = '0;
      fork monitor(); join_none
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      check("rst_codeword", int'(codeword), 0);
      check("rst_syndrome", int'(syndrome), 0);
      check("rst_valid", int'(valid_codeword), 0);
      check("rst_nan", int'(nan_detected), 0);
      reset = 1'b0;

      // Directed vectors (col5..col0)
      issue({32'h3FB70A3D, 32'hBE9EB852, 32'h3F0A3D71, 32'hBE6B851F, 32'hBEF0A3D7, 32'h3F59999A}, 1);
      issue({6{32'h3F800000}}, 1);
      issue({32'h3F800000, 32'hBF800000, 32'h3F800000, 32'h3F800000, 32'hBF800000, 32'hBF800000}, 1);
      issue({32'h7FC00000, 32'h3F800000, 32'h3F800000, 32'h80000000, 32'h3F800000, 32'h3F800000}, 1);

      // start held high: back-to-back runs 11 cycles apart
      wait_idle();
      v = {rand_llr(), rand_llr(), rand_llr(), rand_llr(), rand_llr(), rand_llr()};
      start = 1'b1;
      sum_vector = v;
      e0 = cyc + 1;
      sb.push_back(model(v, e0));
      sb.push_back(model(v, e0 + 11));
      repeat (12) @(posedge clk);
      @(negedge clk);
      start = 1'b0;

      // start with a different vector at E3 is ignored
      issue({6{32'hBF800000}}, 1);
      repeat (2) @(negedge clk);
      start = 1'b1;
      sum_vector = {6{32'h3F800000}};
      @(negedge clk);
      start = 1'b0;

      // reset sampled at E5 aborts the run
      issue({6{32'hC0000000}}, 0);
      repeat (4) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      check("abort_codeword", int'(codeword), 0);
      check("abort_syndrome", int'(syndrome), 0);
      check("abort_valid", int'(valid_codeword), 0);
      check("abort_nan", int'(nan_detected), 0);
      last_cw  = '0;
      last_syn = '0;
      repeat (15) @(negedge clk);
      issue({32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000, 32'h3F800000, 32'hBF800000}, 1);

      // Randomized runs
      for (int i = 0; i < 40; i++) begin
         v = {rand_llr(), rand_llr(), rand_llr(), rand_llr(), rand_llr(), rand_llr()};
         issue(v, 1);
      end

      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("scoreboard_drained", sb.size(), 0);
      repeat (15) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
